hawk_beacon_ctrl: RTL and testbench
===================================

// Module: hawk_beacon_ctrl
// PURPOSE
//  Parametrised, self-timed HAWK pedestrian beacon controller; next generation of the fixed 14-state crosswalk FSM.
//  Internal duration timer driven by an external 1-cycle tick strobe (e.g. 1 Hz prescaler); no external counter.
//  Adds per-phase programmable durations, wig-wag red clearance, enforced vehicle recovery interval, maintenance hold.
//  Sits between the push-button debouncer / tick prescaler and the lamp drivers.
// PARAMETERS
//  TW        8   timer width in bits; must hold max(duration)-1
//  FLASH_Y_T 4   ticks of flashing yellow
//  STEADY_Y_T 3  ticks of steady yellow
//  ALL_RED_T 1   ticks of steady red, DNW steady, before walk
//  WALK_T    7   ticks of steady red + WALK
//  CLEAR_T   10  ticks of wig-wag red + flashing DNW
//  MIN_GO_T  20  ticks of dark (vehicle go) recovery before a new cycle may start
// PORTS
//  clk        in  1   system clock
//  reset_n    in  1   asynchronous active-low reset
//  tick       in  1   1-cycle timebase strobe
//  ped_req    in  1   debounced pedestrian push-button, level
//  force_dark in  1   maintenance hold: block new cycles
//  yl         out 1   yellow lamp
//  rl_a       out 1   red lamp A
//  rl_b       out 1   red lamp B
//  walk       out 1   WALK symbol
//  dnw        out 1   DON'T WALK symbol
//  req_ack    out 1   request-registered indicator (button lamp)
//  busy       out 1   1 in any state other than DARK
//  state      out 3   current state encoding
//  countdown  out TW  remaining walk+clear ticks (HAWK_COUNTDOWN_EN only)
// BEHAVIOUR
//  All outputs registered; on reset_n=0: state=DARK, dnw=1, every other output 0, timer=0, req latch=0, phase=1.
//  States: DARK=0 FLASH_Y=1 STEADY_Y=2 ALL_RED=3 WALK=4 CLEAR=5 MIN_GO=6; codes 7 -> DARK next cycle.
//  Timer: loaded with DUR-1 on every state entry; decrements on tick; phase ends on tick with timer==0.
//   Hence state dwell = DUR ticks, independent of tick alignment at entry (partial first tick not counted).
//  Flash phase bit: set to 1 on state entry (lamp on first), toggles on every tick.
//  Request latch: set by ped_req=1 in any state except WALK; cleared on entry to WALK; req_ack = latch.
//  Transitions: DARK -> FLASH_Y the cycle after latch=1 and force_dark=0; FLASH_Y -> STEADY_Y -> ALL_RED ->
//   WALK -> CLEAR -> MIN_GO -> DARK, each on timer expiry.
//  force_dark: only holds in DARK; it never aborts a cycle in progress (safety); MIN_GO still completes.
//  Lamps: DARK/MIN_GO all dark, dnw=1; FLASH_Y yl=phase, dnw=1; STEADY_Y yl=1, dnw=1;
//   ALL_RED rl_a=rl_b=1, dnw=1; WALK rl_a=rl_b=1, walk=1; CLEAR rl_a=phase, rl_b=~phase, dnw=phase.
//  walk and dnw are never 1 together; yl and any rl never 1 together.
//  ped_req and timer expiry in the same cycle: both take effect (latch set, state advances).
//  Request during WALK ignored; during CLEAR/MIN_GO latched, served after MIN_GO (no back-to-back cycles).
//  Reset mid-cycle: immediate return to DARK, dnw=1, pending request lost.
// CONFIGURATION
//  HAWK_COUNTDOWN_EN defined: countdown = remaining ticks of WALK+CLEAR (WALK_T+CLEAR_T at WALK entry,
//   decrement per tick, 0 outside WALK/CLEAR); needs TW >= clog2(WALK_T+CLEAR_T+1).
//  Undefined: countdown port absent; no extra logic.
// STRUCTURE
//  hawk_pkg: state encodings, lamp-vector struct/constants, clog2 helper.
//  One sub-module: hawk_phase_timer (load, tick decrement, expiry flag, flash phase bit).
//  Elaboration check: every *_T >= 1 and < 2**TW.
// TESTING
//  Reset with ped_req=1 held -> DARK, dnw=1, req_ack=0 during reset, req_ack=1 first cycle after release.
//  ped_req pulse in DARK, tick every 4 clk -> exact dwell 4/3/1/7/10/20 ticks; yl toggles per tick in FLASH_Y.
//  CLEAR: rl_a/rl_b strictly alternate each tick, never both 1; dnw flashes in phase with rl_a.
//  ped_req during WALK -> req_ack stays 0; during MIN_GO -> FLASH_Y starts 1 clk after MIN_GO ends.
//  force_dark=1 + ped_req in DARK -> stays DARK, req_ack=1; release -> FLASH_Y next clk; force_dark mid-WALK -> no effect.
//  HAWK_COUNTDOWN_EN: countdown=17 at WALK entry, 10 at CLEAR entry, 0 in MIN_GO.

Source files
------------

// File: rtl/hawk_pkg.sv
// HAWK beacon shared types: state encodings, lamp vector, lamp decode, clog2.
package hawk_pkg;

  typedef enum logic [2:0] {
    ST_DARK     = 3'd0,
    ST_FLASH_Y  = 3'd1,
    ST_STEADY_Y = 3'd2,
    ST_ALL_RED  = 3'd3,
    ST_WALK     = 3'd4,
    ST_CLEAR    = 3'd5,
    ST_MIN_GO   = 3'd6
  } hawk_state_e;

  typedef struct packed {
    logic yl;
    logic rl_a;
    logic rl_b;
    logic walk;
    logic dnw;
  } hawk_lamps_t;

  // Vehicle go / idle: every lamp dark, pedestrians held at DON'T WALK.
  localparam hawk_lamps_t LAMPS_DARK = '{yl: 1'b0, rl_a: 1'b0, rl_b: 1'b0,
                                         walk: 1'b0, dnw: 1'b1};

  // Lamp pattern for a state given the flash phase (1 = lamp-on half).
  function automatic hawk_lamps_t lamps_for(input hawk_state_e st, input logic ph);
    hawk_lamps_t l;
    l = LAMPS_DARK;
    case (st)
      ST_FLASH_Y:  l.yl = ph;
      ST_STEADY_Y: l.yl = 1'b1;
      ST_ALL_RED: begin
        l.rl_a = 1'b1;
        l.rl_b = 1'b1;
      end
      ST_WALK: begin
        l.rl_a = 1'b1;
        l.rl_b = 1'b1;
        l.walk = 1'b1;
        l.dnw  = 1'b0;
      end
      ST_CLEAR: begin
        // Wig-wag: reds alternate, DON'T WALK flashes with lamp A.
        l.rl_a = ph;
        l.rl_b = ~ph;
        l.dnw  = ph;
      end
      default: l = LAMPS_DARK;
    endcase
    return l;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/hawk_phase_timer.sv
// Phase duration timer: loads DUR-1 on state entry, counts down on tick,
// flags expiry on a tick at zero, and keeps the lamp flash phase bit.
module hawk_phase_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          tick_i,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic          expire_o,
  output logic          phase_d_o
);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  assign expire_o  = tick_i && (cnt_q == '0);
  assign phase_d_o = phase_d;

  // Load has priority so a tick coinciding with entry is not counted.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (load_i) begin
      cnt_d   = load_val_i;
      phase_d = 1'b1;
    end else if (tick_i) begin
      phase_d = ~phase_q;
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter and phase registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/hawk_beacon_ctrl.sv
// HAWK pedestrian beacon controller, self-timed from an external tick strobe.
// Optional build macro HAWK_COUNTDOWN_EN adds the WALK+CLEAR countdown output.
//
// state     | meaning
// ----------+-----------------------------------------------
// DARK      | vehicles go, waiting for a latched request
// FLASH_Y   | flashing yellow warning
// STEADY_Y  | steady yellow
// ALL_RED   | steady red, DON'T WALK still lit
// WALK      | steady red, WALK lit
// CLEAR     | wig-wag red, flashing DON'T WALK
// MIN_GO    | enforced vehicle recovery, lamps dark
module hawk_beacon_ctrl
  import hawk_pkg::*;
#(
  parameter int TW         = 8,
  parameter int FLASH_Y_T  = 4,
  parameter int STEADY_Y_T = 3,
  parameter int ALL_RED_T  = 1,
  parameter int WALK_T     = 7,
  parameter int CLEAR_T    = 10,
  parameter int MIN_GO_T   = 20
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          tick,
  input  logic          ped_req,
  input  logic          force_dark,
  output logic          yl,
  output logic          rl_a,
  output logic          rl_b,
  output logic          walk,
  output logic          dnw,
  output logic          req_ack,
  output logic          busy,
  output logic [2:0]    state
`ifdef HAWK_COUNTDOWN_EN
  ,
  output logic [TW-1:0] countdown
`endif
);

  localparam int TMAX = 1 << TW;

  localparam bit DUR_OK =
    (FLASH_Y_T  >= 1) && (FLASH_Y_T  < TMAX) &&
    (STEADY_Y_T >= 1) && (STEADY_Y_T < TMAX) &&
    (ALL_RED_T  >= 1) && (ALL_RED_T  < TMAX) &&
    (WALK_T     >= 1) && (WALK_T     < TMAX) &&
    (CLEAR_T    >= 1) && (CLEAR_T    < TMAX) &&
    (MIN_GO_T   >= 1) && (MIN_GO_T   < TMAX);

  if (!DUR_OK) begin : g_bad_duration
    $error("hawk_beacon_ctrl: every phase duration must be >= 1 and < 2**TW");
  end

  hawk_state_e   state_q, state_d;
  logic          req_q, req_d;
  hawk_lamps_t   lamps_q, lamps_d;
  logic          busy_q;
  logic          tmr_load, tmr_expire, phase_d;
  logic [TW-1:0] tmr_load_val;

  function automatic logic [TW-1:0] dur_m1(input hawk_state_e st);
    case (st)
      ST_FLASH_Y:  return TW'(FLASH_Y_T - 1);
      ST_STEADY_Y: return TW'(STEADY_Y_T - 1);
      ST_ALL_RED:  return TW'(ALL_RED_T - 1);
      ST_WALK:     return TW'(WALK_T - 1);
      ST_CLEAR:    return TW'(CLEAR_T - 1);
      ST_MIN_GO:   return TW'(MIN_GO_T - 1);
      default:     return '0;
    endcase
  endfunction

  // Next state: force_dark only gates leaving DARK, never aborts a cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DARK:     if (req_q && !force_dark) state_d = ST_FLASH_Y;
      ST_FLASH_Y:  if (tmr_expire) state_d = ST_STEADY_Y;
      ST_STEADY_Y: if (tmr_expire) state_d = ST_ALL_RED;
      ST_ALL_RED:  if (tmr_expire) state_d = ST_WALK;
      ST_WALK:     if (tmr_expire) state_d = ST_CLEAR;
      ST_CLEAR:    if (tmr_expire) state_d = ST_MIN_GO;
      ST_MIN_GO:   if (tmr_expire) state_d = ST_DARK;
      default:     state_d = ST_DARK;
    endcase
  end

  assign tmr_load     = (state_d != state_q);
  assign tmr_load_val = dur_m1(state_d);

  hawk_phase_timer #(.TW(TW)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick_i     (tick),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .expire_o   (tmr_expire),
    .phase_d_o  (phase_d)
  );

  // Request latch; entering WALK serves the request, so the clear wins.
  always_comb begin
    req_d = req_q;
    if (ped_req && state_q != ST_WALK) req_d = 1'b1;
    if (state_d == ST_WALK && state_q != ST_WALK) req_d = 1'b0;
  end

  assign lamps_d = lamps_for(state_d, phase_d);

  // FSM state, request latch and registered lamp/status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_DARK;
      req_q   <= 1'b0;
      lamps_q <= LAMPS_DARK;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      lamps_q <= lamps_d;
      busy_q  <= (state_d != ST_DARK);
    end
  end

  assign yl      = lamps_q.yl;
  assign rl_a    = lamps_q.rl_a;
  assign rl_b    = lamps_q.rl_b;
  assign walk    = lamps_q.walk;
  assign dnw     = lamps_q.dnw;
  assign req_ack = req_q;
  assign busy    = busy_q;
  assign state   = state_q;

`ifdef HAWK_COUNTDOWN_EN
  if (TW < clog2(WALK_T + CLEAR_T + 1)) begin : g_bad_cd_width
    $error("hawk_beacon_ctrl: TW too narrow for the WALK+CLEAR countdown");
  end

  logic [TW-1:0] cd_q, cd_d;

  // Countdown spans WALK and CLEAR; zero everywhere else.
  always_comb begin
    cd_d = '0;
    if (state_d == ST_WALK && state_q != ST_WALK) begin
      cd_d = TW'(WALK_T + CLEAR_T);
    end else if (state_d == ST_WALK || state_d == ST_CLEAR) begin
      cd_d = (tick && cd_q != '0) ? cd_q - 1'b1 : cd_q;
    end
  end

  // Countdown register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cd_q <= '0;
    else          cd_q <= cd_d;
  end

  assign countdown = cd_q;
`endif

endmodule

// File: tb/tb_hawk_beacon_ctrl.sv
// Directed self-checking bench for hawk_beacon_ctrl.
module tb_hawk_beacon_ctrl;

  localparam logic [2:0] S_DARK     = 3'd0;
  localparam logic [2:0] S_FLASH_Y  = 3'd1;
  localparam logic [2:0] S_STEADY_Y = 3'd2;
  localparam logic [2:0] S_ALL_RED  = 3'd3;
  localparam logic [2:0] S_WALK     = 3'd4;
  localparam logic [2:0] S_CLEAR    = 3'd5;
  localparam logic [2:0] S_MIN_GO   = 3'd6;

  logic       clk, reset_n, tick, ped_req, force_dark;
  logic       yl, rl_a, rl_b, walk, dnw, req_ack, busy;
  logic [2:0] state;
`ifdef HAWK_COUNTDOWN_EN
  logic [7:0] countdown;
`endif

  logic       tick_en;
  logic       t_edge;
  int         tcnt;
  int         checks;
  int         errors;

  wire [4:0] lamps = {yl, rl_a, rl_b, walk, dnw};

  hawk_beacon_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .ped_req    (ped_req),
    .force_dark (force_dark),
    .yl         (yl),
    .rl_a       (rl_a),
    .rl_b       (rl_b),
    .walk       (walk),
    .dnw        (dnw),
    .req_ack    (req_ack),
    .busy       (busy),
    .state      (state)
`ifdef HAWK_COUNTDOWN_EN
    ,
    .countdown  (countdown)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tick strobe: one clock high every 4 clocks, changed on the falling edge.
  initial begin
    tick = 1'b0;
    tcnt = 0;
    forever begin
      @(negedge clk);
      tcnt++;
      tick = tick_en && (tcnt % 4 == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected {yl, rl_a, rl_b, walk, dnw} for a state and flash phase.
  function automatic logic [4:0] exp_lamps(input logic [2:0] st, input logic ph);
    case (st)
      S_FLASH_Y:  return {ph, 4'b0001};
      S_STEADY_Y: return 5'b10001;
      S_ALL_RED:  return 5'b01101;
      S_WALK:     return 5'b01110;
      S_CLEAR:    return {1'b0, ph, ~ph, 1'b0, ph};
      default:    return 5'b00001;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    t_edge = tick;
    #1;
  endtask

  // Stay in one phase, checking lamps each clock and counting ticks of dwell.
  task automatic run_phase(input logic [2:0] st, input int exp_ticks,
                           input string tag, input int req_at);
    int  n;
    int  guard;
    logic ph;
    n = 0;
    guard = 0;
    ph = 1'b1;
    chk({tag, " entry state"}, state, st);
    chk({tag, " entry lamps"}, lamps, exp_lamps(st, ph));
`ifdef HAWK_COUNTDOWN_EN
    if (st == S_WALK)   chk({tag, " countdown entry"}, countdown, 17);
    if (st == S_CLEAR)  chk({tag, " countdown entry"}, countdown, 10);
    if (st == S_MIN_GO) chk({tag, " countdown entry"}, countdown, 0);
`endif
    while (state == st && guard < 2000) begin
      ped_req = (guard == req_at);
      step();
      guard++;
      if (t_edge) n++;
      if (state == st) begin
        if (t_edge) ph = ~ph;
        chk({tag, " lamps"}, lamps, exp_lamps(st, ph));
      end
    end
    ped_req = 1'b0;
    chk({tag, " dwell ticks"}, n, exp_ticks);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    tick_en    = 1'b0;
    t_edge     = 1'b0;
    reset_n    = 1'b0;
    ped_req    = 1'b1;
    force_dark = 1'b0;

    // Reset held with the button pressed.
    repeat (3) step();
    chk("rst state", state, S_DARK);
    chk("rst lamps", lamps, 5'b00001);
    chk("rst req_ack", req_ack, 0);
    chk("rst busy", busy, 0);

    reset_n = 1'b1;
    step();
    chk("rel req_ack", req_ack, 1);
    chk("rel state", state, S_DARK);
    step();
    chk("rel to flash", state, S_FLASH_Y);
    chk("rel busy", busy, 1);
    chk("rel yl", yl, 1);

    // Asynchronous reset mid-cycle drops the pending request.
    ped_req = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("async rst state", state, S_DARK);
    chk("async rst lamps", lamps, 5'b00001);
    chk("async rst req_ack", req_ack, 0);
    step();
    reset_n = 1'b1;
    repeat (3) step();
    chk("post rst state", state, S_DARK);
    chk("post rst req_ack", req_ack, 0);

    // Full cycle from a single-clock button press.
    tick_en = 1'b1;
    repeat (2) step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    chk("press req_ack", req_ack, 1);
    chk("press state", state, S_DARK);
    step();
    run_phase(S_FLASH_Y, 4, "flash_y", -1);
    run_phase(S_STEADY_Y, 3, "steady_y", -1);
    run_phase(S_ALL_RED, 1, "all_red", -1);
    chk("walk entry req_ack", req_ack, 0);
    force_dark = 1'b1;
    run_phase(S_WALK, 7, "walk", 2);
    force_dark = 1'b0;
    chk("walk press ignored", req_ack, 0);
    run_phase(S_CLEAR, 10, "clear", -1);
    run_phase(S_MIN_GO, 20, "min_go", 0);
    chk("min_go end state", state, S_DARK);
    chk("min_go req latched", req_ack, 1);
    chk("min_go end busy", busy, 0);
    step();
    chk("served after min_go", state, S_FLASH_Y);

    // Let the second cycle run back to DARK.
    begin
      int guard;
      guard = 0;
      while (state != S_DARK && guard < 400) begin
        step();
        guard++;
      end
    end
    chk("second cycle done", state, S_DARK);
    chk("second cycle req_ack", req_ack, 0);

    // Maintenance hold in DARK.
    force_dark = 1'b1;
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    repeat (10) step();
    chk("hold state", state, S_DARK);
    chk("hold req_ack", req_ack, 1);
    chk("hold busy", busy, 0);
    force_dark = 1'b0;
    step();
    chk("hold release", state, S_FLASH_Y);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
